ecc_hamming_decoder: RTL and testbench

ECC_HAMMING_DECODER -- requirements
Module: ecc_hamming_decoder

---
 rtl/ecc_hamming_pkg.sv | 45 ++++
 rtl/ecc_hamming_syndrome.sv | 28 ++
 rtl/ecc_hamming_decoder.sv | 156 +++++++++++++++
 tb/tb_ecc_hamming_decoder.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ecc_hamming_pkg.sv
// Purpose: shared constants, error classes and index helpers for the Hamming SEC-DED decoder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Codeword bit i carries Hamming position i+1; check bits sit where i+1 is a power of two.

package ecc_hamming_pkg;

    localparam int ECC_DATA_WIDTH    = 32;
    localparam int ECC_PARITY_LENGTH = 6;
    localparam int ECC_CW_WIDTH      = ECC_DATA_WIDTH + ECC_PARITY_LENGTH;

    // Check-bit indices of the default 38-bit codeword.
    localparam int CHECK_IDX [ECC_PARITY_LENGTH] = '{0, 1, 3, 7, 15, 31};

    typedef enum logic [1:0] {
        NONE        = 2'd0,
        SINGLE      = 2'd1,
        PARITY_ONLY = 2'd2,
        DOUBLE      = 2'd3
    } err_class_t;

    // Index i holds a check bit when position i+1 is a power of two.
    function automatic bit is_check_idx(input int i);
        return ((i + 1) & i) == 0;
    endfunction

    // Codeword index of data bit j: the j-th non-check index in ascending order.
    function automatic int data_idx(input int j);
        int n;
        int r;
        n = 0;
        r = 0;
        for (int i = 0; i < 256; i++) begin
            if (!is_check_idx(i)) begin
                if (n == j) begin
                    r = i;
                end
                n++;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/ecc_hamming_syndrome.sv
// Purpose: Hamming syndrome of a codeword; bit k is the XOR of all bits whose position has bit k set.
// Latency: combinational, 0 cycles.
// Backpressure: none (pure function of the input).
//
// Ports: codeword (CW_WIDTH) in, syndrome (PARITY_LENGTH) out.

module ecc_hamming_syndrome
    import ecc_hamming_pkg::*;
#(
    parameter int CW_WIDTH      = ECC_CW_WIDTH,
    parameter int PARITY_LENGTH = ECC_PARITY_LENGTH
) (
    input  logic [CW_WIDTH-1:0]      codeword,
    output logic [PARITY_LENGTH-1:0] syndrome
);

    always_comb begin
        syndrome = '0;
        for (int k = 0; k < PARITY_LENGTH; k++) begin
            for (int i = 0; i < CW_WIDTH; i++) begin
                if ((((i + 1) >> k) & 1) != 0) begin
                    syndrome[k] = syndrome[k] ^ codeword[i];
                end
            end
        end
    end

endmodule

// File: rtl/ecc_hamming_decoder.sv
// Purpose: two-stage SEC-DED Hamming decoder with optional corrected/uncorrectable error counters.
// Latency: 2 cycles from input handshake to out_valid, one word per cycle sustained.
// Backpressure: valid/ready; out_ready low stalls stage 2, then stage 1, then drops in_ready.
//
// Ports: clk, rst (sync, active high); in_valid/in_ready, codeword_in, parity_in (overall even parity);
//        out_valid/out_ready, d_out, err_single, err_double, err_pos; cnt_clr, corr_cnt, uncorr_cnt.
// Build option: define ECC_HAMMING_DEC_ERR_CNT_EN to include the saturating error counters;
//        otherwise the counters read 0 and cnt_clr is ignored.

module ecc_hamming_decoder
    import ecc_hamming_pkg::*;
#(
    parameter int DATA_WIDTH    = ECC_DATA_WIDTH,
    parameter int PARITY_LENGTH = ECC_PARITY_LENGTH,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [DATA_WIDTH+PARITY_LENGTH-1:0] codeword_in,
    input  logic                                parity_in,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [DATA_WIDTH-1:0]               d_out,
    output logic                                err_single,
    output logic                                err_double,
    output logic [PARITY_LENGTH-1:0]            err_pos,
    input  logic                                cnt_clr,
    output logic [CNT_WIDTH-1:0]                corr_cnt,
    output logic [CNT_WIDTH-1:0]                uncorr_cnt
);

    localparam int CWW = DATA_WIDTH + PARITY_LENGTH;

    typedef struct packed {
        logic [CWW-1:0]           cw;
        logic [PARITY_LENGTH-1:0] syn;
        logic                     ov;
    } s1_t;

    logic                     s1_valid;
    logic                     s2_valid;
    s1_t                      s1_d;
    s1_t                      s1_q;
    logic                     en1;
    logic                     en2;
    logic [PARITY_LENGTH-1:0] syn_c;
    err_class_t               cls;
    logic [PARITY_LENGTH-1:0] pos_c;
    logic [CWW-1:0]           cw_fix;
    logic [DATA_WIDTH-1:0]    data_c;

    // ---------------- flow control ----------------
    assign en2      = !s2_valid || out_ready;
    assign en1      = !s1_valid || en2;
    assign in_ready = en1;
    // Gated so nothing can transfer on the cycle reset is being applied.
    assign out_valid = s2_valid && !rst;

    // ---------------- stage 1: syndrome + overall parity ----------------
    ecc_hamming_syndrome #(
        .CW_WIDTH      (CWW),
        .PARITY_LENGTH (PARITY_LENGTH)
    ) u_syndrome (
        .codeword (codeword_in),
        .syndrome (syn_c)
    );

    assign s1_d.cw  = codeword_in;
    assign s1_d.syn = syn_c;
    assign s1_d.ov  = (^codeword_in) ^ parity_in;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else if (en1) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_q <= s1_d;
            end
        end
    end

    // ---------------- stage 2: classify, correct, extract ----------------
    always_comb begin
        cls   = NONE;
        pos_c = '0;
        if (s1_q.syn == '0) begin
            cls = s1_q.ov ? PARITY_ONLY : NONE;
        end else if (!s1_q.ov) begin
            cls = DOUBLE;
        end else if (int'(s1_q.syn) <= CWW) begin
            cls   = SINGLE;
            pos_c = s1_q.syn;
        end else begin
            // Syndrome points past the last codeword position: cannot be a single flip.
            cls = DOUBLE;
        end
    end

    // Only a SINGLE class flips a bit, so DOUBLE words pass through uncorrected.
    for (genvar i = 0; i < CWW; i++) begin : g_fix
        assign cw_fix[i] = s1_q.cw[i] ^ ((cls == SINGLE) && (s1_q.syn == PARITY_LENGTH'(i + 1)));
    end

    for (genvar j = 0; j < DATA_WIDTH; j++) begin : g_extract
        assign data_c[j] = cw_fix[data_idx(j)];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid   <= 1'b0;
            d_out      <= '0;
            err_single <= 1'b0;
            err_double <= 1'b0;
            err_pos    <= '0;
        end else if (en2) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                d_out      <= data_c;
                err_single <= (cls == SINGLE) || (cls == PARITY_ONLY);
                err_double <= (cls == DOUBLE);
                err_pos    <= pos_c;
            end
        end
    end

    // ---------------- error counters ----------------
`ifdef ECC_HAMMING_DEC_ERR_CNT_EN
    logic out_xfer;
    assign out_xfer = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            // Clear wins over an increment in the same cycle.
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
        end else if (out_xfer) begin
            if (err_single && (corr_cnt != '1)) begin
                corr_cnt <= corr_cnt + 1'b1;
            end
            if (err_double && (uncorr_cnt != '1)) begin
                uncorr_cnt <= uncorr_cnt + 1'b1;
            end
        end
    end
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign corr_cnt       = '0;
    assign uncorr_cnt     = '0;
`endif

endmodule

// File: tb/tb_ecc_hamming_decoder.sv
// Purpose: directed self-checking bench for ecc_hamming_decoder (decode classes, latency, stalls, counters, reset).
// Latency: expects results 2 cycles after the input handshake.
// Backpressure: exercised with an out_ready stall window while streaming.

module tb_ecc_hamming_decoder;

`ifdef ECC_HAMMING_DEC_ERR_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [37:0] codeword_in = '0;
    logic        parity_in = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] d_out;
    logic        err_single;
    logic        err_double;
    logic [5:0]  err_pos;
    logic        cnt_clr = 1'b0;
    logic [3:0]  corr_cnt;
    logic [3:0]  uncorr_cnt;

    int checks = 0;
    int errors = 0;
    logic [3:0] exp_corr = '0;
    logic [3:0] exp_uncorr = '0;

    always #5 clk = ~clk;

    ecc_hamming_decoder #(
        .CNT_WIDTH (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .codeword_in (codeword_in),
        .parity_in   (parity_in),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .d_out       (d_out),
        .err_single  (err_single),
        .err_double  (err_double),
        .err_pos     (err_pos),
        .cnt_clr     (cnt_clr),
        .corr_cnt    (corr_cnt),
        .uncorr_cnt  (uncorr_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counter model: saturating 4-bit counts, or constant zero without the counter build.
    task automatic note_xfer(input bit s, input bit d);
        if (CNT_EN) begin
            if (s && exp_corr != 4'hF) exp_corr = exp_corr + 4'd1;
            if (d && exp_uncorr != 4'hF) exp_uncorr = exp_uncorr + 4'd1;
        end
    endtask

    // Drives one word into an empty pipeline, returns the result and the observed latency (-1 on timeout).
    task automatic send_one(input logic [37:0] cw, input logic par,
                            output logic [31:0] d, output logic es, output logic ed,
                            output logic [5:0] pos, output int lat);
        codeword_in = cw;
        parity_in   = par;
        in_valid    = 1'b1;
        out_ready   = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = -1;
        d = '0; es = 1'b0; ed = 1'b0; pos = '0;
        for (int c = 1; c <= 10; c++) begin
            if (out_valid) begin
                lat = c;
                break;
            end
            tick();
        end
        if (lat > 0) begin
            d   = d_out;
            es  = err_single;
            ed  = err_double;
            pos = err_pos;
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if ({out_valid, in_ready, d_out, err_single, err_double, err_pos} !== {1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 6'd0}) begin
            errors++;
            $display("FAIL reset_state: got v=%b rdy=%b d=%h s=%b d2=%b pos=%0d, want v=0 rdy=1 d=0 s=0 d2=0 pos=0",
                     out_valid, in_ready, d_out, err_single, err_double, err_pos);
        end
        checks++;
        if ({corr_cnt, uncorr_cnt} !== 8'h00) begin
            errors++;
            $display("FAIL reset_counters: got corr=%0d uncorr=%0d, want 0 0", corr_cnt, uncorr_cnt);
        end
    endtask

    typedef struct {
        logic [37:0] cw;
        logic        par;
        logic [31:0] d;
        logic        es;
        logic        ed;
        logic [5:0]  pos;
    } vec_t;

    task automatic test_decode();
        vec_t v[10];
        string nm[10];
        logic [31:0] d;
        logic es, ed;
        logic [5:0] pos;
        int lat;
        v[0] = '{38'h7,          1'b1, 32'h1,   1'b0, 1'b0, 6'd0};  nm[0] = "clean_d1";
        v[1] = '{38'h19,         1'b1, 32'h2,   1'b0, 1'b0, 6'd0};  nm[1] = "clean_d2";
        v[2] = '{38'h3,          1'b1, 32'h1,   1'b1, 1'b0, 6'd3};  nm[2] = "single_pos3";
        v[3] = '{38'h09,         1'b1, 32'h2,   1'b1, 1'b0, 6'd5};  nm[3] = "single_pos5";
        v[4] = '{38'h0,          1'b1, 32'h0,   1'b1, 1'b0, 6'd0};  nm[4] = "parity_only";
        v[5] = '{38'h20_0000_0000, 1'b0, 32'h0, 1'b1, 1'b0, 6'd38}; nm[5] = "single_pos38";
        v[6] = '{38'h4,          1'b1, 32'h1,   1'b0, 1'b1, 6'd0};  nm[6] = "double_ov0";
        v[7] = '{38'h0_8000_C000, 1'b0, 32'h400, 1'b0, 1'b1, 6'd0}; nm[7] = "double_syn63";
        v[8] = '{38'h0_8000_0040, 1'b1, 32'h8,  1'b0, 1'b1, 6'd0};  nm[8] = "double_syn39";
        v[9] = '{38'h0,          1'b0, 32'h0,   1'b0, 1'b0, 6'd0};  nm[9] = "clean_zero";
        for (int k = 0; k < 10; k++) begin
            send_one(v[k].cw, v[k].par, d, es, ed, pos, lat);
            note_xfer(v[k].es, v[k].ed);
            checks++;
            if (lat !== 2) begin
                errors++;
                $display("FAIL %s_latency: got %0d cycles, want 2", nm[k], lat);
            end
            checks++;
            if ({d, es, ed, pos} !== {v[k].d, v[k].es, v[k].ed, v[k].pos}) begin
                errors++;
                $display("FAIL %s: got d=%h s=%b d2=%b pos=%0d, want d=%h s=%b d2=%b pos=%0d",
                         nm[k], d, es, ed, pos, v[k].d, v[k].es, v[k].ed, v[k].pos);
            end
            checks++;
            if ({corr_cnt, uncorr_cnt} !== {exp_corr, exp_uncorr}) begin
                errors++;
                $display("FAIL %s_counters: got corr=%0d uncorr=%0d, want corr=%0d uncorr=%0d",
                         nm[k], corr_cnt, uncorr_cnt, exp_corr, exp_uncorr);
            end
        end
    endtask

    task automatic test_back_to_back();
        int  sent;
        int  rcv;
        int  low_cnt;
        logic acc;
        sent = 0;
        rcv = 0;
        low_cnt = 0;
        for (int cyc = 0; cyc < 60 && rcv < 8; cyc++) begin
            out_ready   = !(cyc >= 3 && cyc <= 6);
            in_valid    = (sent < 8);
            codeword_in = 38'd1 << sent;
            parity_in   = 1'b0;
            #1;
            if (!in_ready) low_cnt++;
            if (cyc >= 3 && cyc <= 6) begin
                checks++;
                if ({out_valid, err_single, err_pos, d_out} !== {1'b1, 1'b1, 6'd2, 32'h0}) begin
                    errors++;
                    $display("FAIL stall_hold cyc%0d: got v=%b s=%b pos=%0d d=%h, want v=1 s=1 pos=2 d=0",
                             cyc, out_valid, err_single, err_pos, d_out);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if ({err_single, err_pos, d_out} !== {1'b1, 6'(rcv + 1), 32'h0}) begin
                    errors++;
                    $display("FAIL stream_order word%0d: got s=%b pos=%0d d=%h, want s=1 pos=%0d d=0",
                             rcv, err_single, err_pos, d_out, rcv + 1);
                end
                rcv++;
                note_xfer(1'b1, 1'b0);
            end
            acc = in_valid && in_ready;
            tick();
            if (acc) sent++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (rcv !== 8) begin
            errors++;
            $display("FAIL stream_count: got %0d words, want 8", rcv);
        end
        checks++;
        if (low_cnt !== 4) begin
            errors++;
            $display("FAIL stream_in_ready_low: got %0d cycles, want 4", low_cnt);
        end
        checks++;
        if ({corr_cnt, uncorr_cnt} !== {exp_corr, exp_uncorr}) begin
            errors++;
            $display("FAIL stream_counters: got corr=%0d uncorr=%0d, want corr=%0d uncorr=%0d",
                     corr_cnt, uncorr_cnt, exp_corr, exp_uncorr);
        end
    endtask

    task automatic test_counters();
        logic [31:0] d;
        logic es, ed;
        logic [5:0] pos;
        int lat;
        for (int k = 0; k < 20; k++) begin
            send_one(38'd1 << (k % 8), 1'b0, d, es, ed, pos, lat);
            note_xfer(1'b1, 1'b0);
        end
        checks++;
        if (corr_cnt !== exp_corr) begin
            errors++;
            $display("FAIL corr_saturate: got %0d, want %0d", corr_cnt, exp_corr);
        end
        cnt_clr = 1'b1;
        send_one(38'd1, 1'b0, d, es, ed, pos, lat);
        cnt_clr = 1'b0;
        exp_corr = '0;
        exp_uncorr = '0;
        checks++;
        if ({corr_cnt, uncorr_cnt} !== {exp_corr, exp_uncorr}) begin
            errors++;
            $display("FAIL clr_wins: got corr=%0d uncorr=%0d, want 0 0", corr_cnt, uncorr_cnt);
        end
        checks++;
        if ({lat, es, pos} !== {32'sd2, 1'b1, 6'd1}) begin
            errors++;
            $display("FAIL clr_word: got lat=%0d s=%b pos=%0d, want lat=2 s=1 pos=1", lat, es, pos);
        end
    endtask

    task automatic test_reset_in_flight();
        int seen;
        out_ready   = 1'b0;
        in_valid    = 1'b1;
        parity_in   = 1'b1;
        codeword_in = 38'h3;
        tick();
        codeword_in = 38'h09;
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL flight_loaded: got out_valid=%b, want 1", out_valid);
        end
        rst = 1'b1;
        out_ready = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_cycle_no_xfer: got out_valid=%b, want 0", out_valid);
        end
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if ({out_valid, in_ready, err_single, err_pos, d_out} !== {1'b0, 1'b1, 1'b0, 6'd0, 32'h0}) begin
            errors++;
            $display("FAIL reset_flush: got v=%b rdy=%b s=%b pos=%0d d=%h, want v=0 rdy=1 s=0 pos=0 d=0",
                     out_valid, in_ready, err_single, err_pos, d_out);
        end
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            if (out_valid) seen++;
            tick();
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL reset_discard: got %0d stray outputs, want 0", seen);
        end
        checks++;
        if ({corr_cnt, uncorr_cnt} !== 8'h00) begin
            errors++;
            $display("FAIL reset_counters_after: got corr=%0d uncorr=%0d, want 0 0", corr_cnt, uncorr_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_back_to_back();
        test_counters();
        test_reset_in_flight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
